// File: rtl/flit_distributor.sv
// Wormhole 1-to-N flit distributor: a 2-entry input queue feeds a lane-locking FSM.
// Optional DISTRIB_ERR_CHECK_EN macro enables out-of-range packet dropping and a sticky err flag.
module flit_distributor #(
    parameter int                    FLIT_SIZE   = 32,
    parameter int                    HEADER_LEN  = 2,
    parameter logic [HEADER_LEN-1:0] HEAD_FLIT   = 2'b00,
    parameter logic [HEADER_LEN-1:0] BODY_FLIT   = 2'b01,
    parameter logic [HEADER_LEN-1:0] TAIL_FLIT   = 2'b10,
    parameter logic [HEADER_LEN-1:0] SINGLE_FLIT = 2'b11,
    parameter int                    N           = 3,
    parameter int                    PORT_LEN    = 2,
    parameter int                    PORT_POS    = FLIT_SIZE - HEADER_LEN - 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [FLIT_SIZE-1:0]   in,
    input  logic                   in_valid,
    output logic                   in_avail,
    output logic [FLIT_SIZE*N-1:0] out,
    output logic [N-1:0]           out_valid,
    input  logic [N-1:0]           out_avail,
    output logic                   err
);

`ifdef DISTRIB_ERR_CHECK_EN
    localparam bit ERR_CHECK = 1'b1;
`else
    localparam bit ERR_CHECK = 1'b0;
`endif

    localparam logic [PORT_LEN-1:0] LAST_LANE = PORT_LEN'(N - 1);

    typedef enum logic [1:0] {IDLE, LOCKED, DROP} state_e;

    state_e                state_q, state_d;
    logic [FLIT_SIZE-1:0]  mem_q [2];
    logic [FLIT_SIZE-1:0]  mem_d [2];
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic [1:0]            count_q, count_d;
    logic [PORT_LEN-1:0]   lock_q, lock_d;
    logic                  err_q, err_d;

    logic                  full, empty, push, pop;
    logic [FLIT_SIZE-1:0]  head;
    logic [HEADER_LEN-1:0] head_type;
    logic [PORT_LEN-1:0]   head_port, tgt;
    logic                  is_start, is_tail, port_oor;
    logic [N-1:0]          valid;

    assign full      = (count_q == 2'd2);
    assign empty     = (count_q == 2'd0);
    assign in_avail  = ~full;
    assign push      = in_valid && !full;

    assign head      = mem_q[rd_ptr_q];
    assign head_type = head[FLIT_SIZE-1 -: HEADER_LEN];
    assign head_port = head[PORT_POS -: PORT_LEN];
    assign is_start  = (head_type == HEAD_FLIT) || (head_type == SINGLE_FLIT);
    assign is_tail   = (head_type == TAIL_FLIT);
    assign port_oor  = int'(head_port) >= N;
    assign tgt       = port_oor ? LAST_LANE : head_port;

    assign out       = {N{head}};
    assign out_valid = valid;
    assign err       = err_q;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        err_d   = err_q;
        pop     = 1'b0;
        valid   = '0;

        if (!rst && !empty) begin
            unique case (state_q)
                IDLE: begin
                    if (!is_start) begin
                        pop = 1'b1;
                        if (ERR_CHECK) err_d = 1'b1;
                    end else if (ERR_CHECK && port_oor) begin
                        pop   = 1'b1;
                        err_d = 1'b1;
                        if (head_type == HEAD_FLIT) state_d = DROP;
                    end else if (out_avail[tgt]) begin
                        valid[tgt] = 1'b1;
                        pop        = 1'b1;
                        if (head_type == HEAD_FLIT) begin
                            state_d = LOCKED;
                            lock_d  = tgt;
                        end
                    end
                end
                LOCKED: begin
                    if (ERR_CHECK && is_start) err_d = 1'b1;
                    if (out_avail[lock_q]) begin
                        valid[lock_q] = 1'b1;
                        pop           = 1'b1;
                        if (is_tail) state_d = IDLE;
                    end
                end
                DROP: begin
                    pop = 1'b1;
                    if (is_tail) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = in;
        wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
        count_d  = count_q + 2'(push) - 2'(pop);
    end

    // NOTE: sequential state is updated with non-blocking assignments so all flops sample together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            lock_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            lock_q   <= lock_d;
            err_q    <= err_d;
        end
    end

    // NOTE: queue storage is not reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_flit_distributor.sv
// Directed self-checking bench for flit_distributor (N=3); expectations follow DISTRIB_ERR_CHECK_EN if defined.
module tb_flit_distributor;

    localparam int N  = 3;
    localparam int FS = 32;
    localparam logic [1:0] HEAD   = 2'b00;
    localparam logic [1:0] BODY   = 2'b01;
    localparam logic [1:0] TAIL   = 2'b10;
    localparam logic [1:0] SINGLE = 2'b11;

`ifdef DISTRIB_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [FS-1:0]   in;
    logic            in_valid;
    logic            in_avail;
    logic [FS*N-1:0] out;
    logic [N-1:0]    out_valid;
    logic [N-1:0]    out_avail;
    logic            err;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    flit_distributor #(.N(N), .FLIT_SIZE(FS), .HEADER_LEN(2), .PORT_LEN(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .in_valid  (in_valid),
        .in_avail  (in_avail),
        .out       (out),
        .out_valid (out_valid),
        .out_avail (out_avail),
        .err       (err)
    );

    function automatic logic [FS-1:0] mk(input logic [1:0] t, input logic [1:0] p, input logic [27:0] pay);
        return {t, p, pay};
    endfunction

    function automatic logic [FS-1:0] lane(input int i);
        return out[FS*i +: FS];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later, well before the rising edge.
    task automatic step(input logic r, input logic v, input logic [FS-1:0] f, input logic [N-1:0] a);
        @(negedge clk);
        rst       = r;
        in_valid  = v;
        in        = f;
        out_avail = a;
        #1;
    endtask

    logic [FS-1:0] h1, b1, t1, s2, s0, h0, b0, t0, lost, h2, t2, orph, h3, t3;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in = '0; out_avail = 3'b111;
        h1 = mk(HEAD, 2'd1, 28'h0000A01);  b1 = mk(BODY, 2'd0, 28'h0000B01);
        t1 = mk(TAIL, 2'd3, 28'h0000C01);  s2 = mk(SINGLE, 2'd2, 28'h0000D02);
        s0 = mk(SINGLE, 2'd0, 28'h0000D00); h0 = mk(HEAD, 2'd0, 28'h0000A00);
        b0 = mk(BODY, 2'd1, 28'h0000B00);  t0 = mk(TAIL, 2'd2, 28'h0000C00);
        lost = mk(SINGLE, 2'd1, 28'h0000EEE); h2 = mk(HEAD, 2'd2, 28'h0000A02);
        t2 = mk(TAIL, 2'd0, 28'h0000C02);  orph = mk(TAIL, 2'd1, 28'h0000F00);
        h3 = mk(HEAD, 2'd3, 28'h0000A03);  t3 = mk(TAIL, 2'd0, 28'h0000C03);

        // Reset
        step(1'b1, 1'b0, '0, 3'b111);
        step(1'b1, 1'b0, '0, 3'b111);
        check("rst_valid", out_valid, 3'b000);
        step(1'b0, 1'b0, '0, 3'b111);
        check("post_rst_avail", in_avail, 1'b1);
        check("post_rst_valid", out_valid, 3'b000);
        check("post_rst_err", err, 1'b0);

        // HEAD(p=1), BODY, TAIL back-to-back
        step(1'b0, 1'b1, h1, 3'b111);
        check("pkt1_c0_valid", out_valid, 3'b000);
        step(1'b0, 1'b1, b1, 3'b111);
        check("pkt1_head_valid", out_valid, 3'b010);
        check("pkt1_head_data", lane(1), h1);
        step(1'b0, 1'b1, t1, 3'b111);
        check("pkt1_body_valid", out_valid, 3'b010);
        check("pkt1_body_data", lane(1), b1);
        step(1'b0, 1'b0, '0, 3'b111);
        check("pkt1_tail_valid", out_valid, 3'b010);
        check("pkt1_tail_data", lane(1), t1);

        // SINGLE(p=2) then SINGLE(p=0): no lock between them
        step(1'b0, 1'b1, s2, 3'b111);
        check("pkt1_done_valid", out_valid, 3'b000);
        step(1'b0, 1'b1, s0, 3'b111);
        check("single2_valid", out_valid, 3'b100);
        check("single2_data", lane(2), s2);
        step(1'b0, 1'b0, '0, 3'b111);
        check("single0_valid", out_valid, 3'b001);
        check("single0_data", lane(0), s0);
        step(1'b0, 1'b0, '0, 3'b111);
        check("singles_done", out_valid, 3'b000);

        // HEAD(p=0) then lane 0 stalls for 4 cycles with BODY/TAIL queued
        step(1'b0, 1'b1, h0, 3'b111);
        step(1'b0, 1'b1, b0, 3'b111);
        check("stall_head_valid", out_valid, 3'b001);
        step(1'b0, 1'b1, t0, 3'b110);
        check("stall_c1_valid", out_valid, 3'b000);
        step(1'b0, 1'b0, '0, 3'b110);
        check("stall_c2_valid", out_valid, 3'b000);
        check("stall_full", in_avail, 1'b0);
        step(1'b0, 1'b1, lost, 3'b110);
        check("stall_c3_valid", out_valid, 3'b000);
        check("stall_c3_full", in_avail, 1'b0);
        step(1'b0, 1'b0, '0, 3'b110);
        check("stall_c4_valid", out_valid, 3'b000);
        step(1'b0, 1'b0, '0, 3'b111);
        check("resume_body_valid", out_valid, 3'b001);
        check("resume_body_data", lane(0), b0);
        step(1'b0, 1'b0, '0, 3'b111);
        check("resume_tail_valid", out_valid, 3'b001);
        check("resume_tail_data", lane(0), t0);
        step(1'b0, 1'b0, '0, 3'b111);
        check("lost_flit_absent", out_valid, 3'b000);
        check("drained_avail", in_avail, 1'b1);

        // HEAD(p=2) stalled by out_avail=011
        step(1'b0, 1'b1, h2, 3'b011);
        step(1'b0, 1'b0, '0, 3'b011);
        check("lane2_stall_c1", out_valid, 3'b000);
        step(1'b0, 1'b0, '0, 3'b011);
        check("lane2_stall_c2", out_valid, 3'b000);
        step(1'b0, 1'b0, '0, 3'b111);
        check("lane2_head_valid", out_valid, 3'b100);
        check("lane2_head_data", lane(2), h2);
        step(1'b0, 1'b1, t2, 3'b111);
        check("lane2_empty_locked", out_valid, 3'b000);
        step(1'b0, 1'b0, '0, 3'b011);
        check("lane2_tail_stall", out_valid, 3'b000);
        step(1'b0, 1'b0, '0, 3'b111);
        check("lane2_tail_valid", out_valid, 3'b100);
        check("lane2_tail_data", lane(2), t2);

        // Orphan TAIL, then HEAD with out-of-range port 3
        step(1'b0, 1'b1, orph, 3'b111);
        check("orphan_c0_valid", out_valid, 3'b000);
        step(1'b0, 1'b1, h3, 3'b111);
        check("orphan_dropped", out_valid, 3'b000);
        step(1'b0, 1'b1, t3, 3'b111);
        check("oor_head_valid", out_valid, ERR_EN ? 3'b000 : 3'b100);
        check("oor_err_set", err, ERR_EN);
        step(1'b0, 1'b0, '0, 3'b111);
        check("oor_tail_valid", out_valid, ERR_EN ? 3'b000 : 3'b100);
        step(1'b0, 1'b0, '0, 3'b111);
        check("oor_done_valid", out_valid, 3'b000);
        check("oor_err_sticky", err, ERR_EN);

        // Reset in the middle of a packet
        step(1'b0, 1'b1, h1, 3'b111);
        step(1'b0, 1'b1, b1, 3'b111);
        check("midrst_head_valid", out_valid, 3'b010);
        step(1'b1, 1'b0, '0, 3'b111);
        check("midrst_during_valid", out_valid, 3'b000);
        step(1'b0, 1'b1, b1, 3'b111);
        check("midrst_after_valid", out_valid, 3'b000);
        check("midrst_after_avail", in_avail, 1'b1);
        check("midrst_err_clear", err, 1'b0);
        step(1'b0, 1'b0, '0, 3'b111);
        check("midrst_orphan_drop", out_valid, 3'b000);
        step(1'b0, 1'b0, '0, 3'b111);
        check("midrst_final_valid", out_valid, 3'b000);
        check("midrst_orphan_err", err, ERR_EN);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
